spi_ram_ctrl: RTL and testbench

//  Parametrised command-decoded RAM behind the SPI slave. Accepts {cmd[1:0], payload} words from
//  the SPI slave and sets write/read pointers, writes data, or returns read data. Successor to the

---
 rtl/spi_ram_pkg.sv | 17 +
 rtl/spi_ram_ctrl_if.sv | 25 ++
 rtl/spi_ram_array.sv | 31 +++
 rtl/spi_ram_ctrl.sv | 151 +++++++++++++++
 tb/tb_spi_ram_ctrl.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_ram_pkg.sv
// Shared types for the SPI RAM controller: command encoding and FSM states.
package spi_ram_pkg;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_HOLD
  } state_e;

endpackage

// File: rtl/spi_ram_ctrl_if.sv
// Command/response bus between the SPI slave (master side) and the RAM controller (slave side).
interface spi_ram_ctrl_if #(
  parameter int PAY_W  = 8,
  parameter int DATA_W = 8
);

  logic              rx_valid;
  logic [PAY_W+1:0]  din;
  logic              rx_ready;
  logic [DATA_W-1:0] dout;
  logic              tx_valid;
  logic              tx_ready;
  logic              err;

  modport slave (
    input  rx_valid, din, tx_ready,
    output rx_ready, dout, tx_valid, err
  );

  modport master (
    output rx_valid, din, tx_ready,
    input  rx_ready, dout, tx_valid, err
  );

endinterface

// File: rtl/spi_ram_array.sv
// Storage array: one write port and one registered read port, contents never reset.
module spi_ram_array #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Write port: store the word on the edge where a write is requested.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read port: capture the addressed word so it is ready one cycle later.
  always_ff @(posedge clk_i) begin
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/spi_ram_ctrl.sv
// Command-decoded RAM: pointer set-up, writes, and handshaked reads for the SPI slave.
module spi_ram_ctrl #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256,
  parameter int PAY_W     = 8,
  parameter int AUTO_INC  = 1
) (
  input logic           clk,
  input logic           rst,
  spi_ram_ctrl_if.slave ram_if
);
  import spi_ram_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(MEM_DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              tx_valid_q, tx_valid_d;
  logic              err_q, err_d;

  cmd_e              cmd;
  logic [PAY_W-1:0]  payload;
  logic [ADDR_W-1:0] pay_addr;
  logic              addr_ok;
  logic              accept;
  logic              rx_ready;
  logic              load_dout;
  logic              release_tx;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] rdata;

  // Pointer increment that wraps at the last legal word, also for non power-of-2 depths.
  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    return (p == LAST_ADDR) ? '0 : p + 1'b1;
  endfunction

  assign cmd      = cmd_e'(ram_if.din[PAY_W+1:PAY_W]);
  assign payload  = ram_if.din[PAY_W-1:0];
  assign pay_addr = payload[ADDR_W-1:0];
  assign addr_ok  = {1'b0, pay_addr} < DEPTH_EXT;
  assign accept   = ram_if.rx_valid & rx_ready;

  // State register: reset aborts any read in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state: a read walks IDLE -> READ -> HOLD and returns once downstream takes the data.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && cmd == CMD_RD_DATA) state_d = S_READ;
      S_READ:  state_d = S_HOLD;
      S_HOLD:  if (ram_if.tx_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: commands are only taken in IDLE; READ loads dout; HOLD waits for tx_ready.
  always_comb begin
    rx_ready   = 1'b0;
    load_dout  = 1'b0;
    release_tx = 1'b0;
    case (state_q)
      S_IDLE:  rx_ready   = 1'b1;
      S_READ:  load_dout  = 1'b1;
      S_HOLD:  release_tx = ram_if.tx_ready;
      default: rx_ready   = 1'b0;
    endcase
  end

  // Command decode: pointer updates with range check, array strobes and response registers.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    err_d      = 1'b0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    dout_d     = dout_q;
    tx_valid_d = tx_valid_q;
    if (accept) begin
      case (cmd)
        CMD_WR_ADDR: begin
          if (addr_ok) wr_ptr_d = pay_addr;
          else         err_d    = 1'b1;
        end
        CMD_WR_DATA: begin
          mem_we = 1'b1;
          if (AUTO_INC != 0) wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        CMD_RD_ADDR: begin
          if (addr_ok) rd_ptr_d = pay_addr;
          else         err_d    = 1'b1;
        end
        CMD_RD_DATA: begin
          mem_re = 1'b1;
          if (AUTO_INC != 0) rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        default: err_d = 1'b0;
      endcase
    end
    if (load_dout) begin
      dout_d     = rdata;
      tx_valid_d = 1'b1;
    end
    if (release_tx) tx_valid_d = 1'b0;
  end

  // Pointer and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      dout_q     <= '0;
      tx_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      dout_q     <= dout_d;
      tx_valid_q <= tx_valid_d;
      err_q      <= err_d;
    end
  end

  spi_ram_array #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_array (
    .clk_i   (clk),
    .we_i    (mem_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (payload[DATA_W-1:0]),
    .re_i    (mem_re),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  assign ram_if.rx_ready = rx_ready;
  assign ram_if.dout     = dout_q;
  assign ram_if.tx_valid = tx_valid_q;
  assign ram_if.err      = err_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Bench for spi_ram_ctrl: three instances (default, depth 200, no auto-increment) share stimulus.
module tb_spi_ram_ctrl;
  import spi_ram_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxValid;
  logic [1:0] cmdIn;
  logic [7:0] payIn;
  logic       txReady;
  int         checks = 0;
  int         errors = 0;

  typedef struct {
    logic       rv;
    logic [1:0] cmd;
    logic [7:0] pay;
    logic       tr;
    logic       expRdy;
    logic       expTv;
    logic [7:0] expDout;
    logic       expErr;
  } vec_t;

  vec_t vecs[$];

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  spi_ram_ctrl_if #(.PAY_W(8), .DATA_W(8)) if0 ();
  spi_ram_ctrl_if #(.PAY_W(8), .DATA_W(8)) if1 ();
  spi_ram_ctrl_if #(.PAY_W(8), .DATA_W(8)) if2 ();

  assign if0.rx_valid = rxValid;
  assign if0.din      = {cmdIn, payIn};
  assign if0.tx_ready = txReady;
  assign if1.rx_valid = rxValid;
  assign if1.din      = {cmdIn, payIn};
  assign if1.tx_ready = txReady;
  assign if2.rx_valid = rxValid;
  assign if2.din      = {cmdIn, payIn};
  assign if2.tx_ready = txReady;

  spi_ram_ctrl #(.MEM_DEPTH(256), .AUTO_INC(1)) dut0 (.clk(clk), .rst(rst), .ram_if(if0.slave));
  spi_ram_ctrl #(.MEM_DEPTH(200), .AUTO_INC(1)) dut1 (.clk(clk), .rst(rst), .ram_if(if1.slave));
  spi_ram_ctrl #(.MEM_DEPTH(256), .AUTO_INC(0)) dut2 (.clk(clk), .rst(rst), .ram_if(if2.slave));

  function automatic logic [7:0] doutOf(input int sel);
    case (sel)
      1:       return if1.dout;
      2:       return if2.dout;
      default: return if0.dout;
    endcase
  endfunction

  function automatic logic tvOf(input int sel);
    case (sel)
      1:       return if1.tx_valid;
      2:       return if2.tx_valid;
      default: return if0.tx_valid;
    endcase
  endfunction

  function automatic vec_t mk(input logic rv, input logic [1:0] c, input logic [7:0] p,
                              input logic tr, input logic eRdy, input logic eTv,
                              input logic [7:0] eDout, input logic eErr);
    vec_t v;
    v.rv = rv; v.cmd = c; v.pay = p; v.tr = tr;
    v.expRdy = eRdy; v.expTv = eTv; v.expDout = eDout; v.expErr = eErr;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rv, input logic [1:0] c, input logic [7:0] p,
                               input logic tr);
    rxValid = rv;
    cmdIn   = c;
    payIn   = p;
    txReady = tr;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic sendCmd(input logic [1:0] c, input logic [7:0] p);
    applyStimulus(1'b1, c, p, 1'b1);
    tick();
  endtask

  task automatic idleCycle(input logic tr);
    applyStimulus(1'b0, CMD_WR_ADDR, 8'h00, tr);
    tick();
  endtask

  task automatic readAndCheck(input string name, input int sel, input logic [7:0] exp);
    applyStimulus(1'b1, CMD_RD_DATA, 8'h00, 1'b1);
    tick();
    checkOutput({name, " rx_ready in READ"}, if0.rx_ready, 0);
    checkOutput({name, " tx_valid in READ"}, tvOf(sel), 0);
    idleCycle(1'b1);
    checkOutput({name, " tx_valid in HOLD"}, tvOf(sel), 1);
    checkOutput({name, " dout"}, doutOf(sel), exp);
    idleCycle(1'b1);
    checkOutput({name, " tx_valid after accept"}, tvOf(sel), 0);
    checkOutput({name, " dout held"}, doutOf(sel), exp);
  endtask

  // Watchdog so the run always ends even if the stimulus stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  // Main directed sequence.
  initial begin
    // Test 1: basic write/read, tx_valid one cycle with tx_ready high.
    vecs.push_back(mk(1, CMD_WR_ADDR, 8'h05, 1, 1, 0, 8'h00, 0));
    vecs.push_back(mk(1, CMD_WR_DATA, 8'hA5, 1, 1, 0, 8'h00, 0));
    vecs.push_back(mk(1, CMD_RD_ADDR, 8'h05, 1, 1, 0, 8'h00, 0));
    vecs.push_back(mk(0, CMD_RD_DATA, 8'h00, 1, 1, 0, 8'h00, 0));
    vecs.push_back(mk(1, CMD_RD_DATA, 8'h00, 1, 0, 0, 8'h00, 0));
    vecs.push_back(mk(0, CMD_WR_ADDR, 8'h00, 1, 0, 1, 8'hA5, 0));
    vecs.push_back(mk(0, CMD_WR_ADDR, 8'h00, 1, 1, 0, 8'hA5, 0));
    // Test 2: auto-increment across the 0xFF -> 0x00 wrap.
    vecs.push_back(mk(1, CMD_WR_ADDR, 8'hFE, 1, 1, 0, 8'hA5, 0));
    vecs.push_back(mk(1, CMD_WR_DATA, 8'h11, 1, 1, 0, 8'hA5, 0));
    vecs.push_back(mk(1, CMD_WR_DATA, 8'h22, 1, 1, 0, 8'hA5, 0));
    vecs.push_back(mk(1, CMD_WR_DATA, 8'h33, 1, 1, 0, 8'hA5, 0));
    vecs.push_back(mk(1, CMD_RD_ADDR, 8'hFE, 1, 1, 0, 8'hA5, 0));
    vecs.push_back(mk(1, CMD_RD_DATA, 8'h00, 1, 0, 0, 8'hA5, 0));
    vecs.push_back(mk(0, CMD_WR_ADDR, 8'h00, 1, 0, 1, 8'h11, 0));
    vecs.push_back(mk(0, CMD_WR_ADDR, 8'h00, 1, 1, 0, 8'h11, 0));
    vecs.push_back(mk(1, CMD_RD_DATA, 8'h00, 1, 0, 0, 8'h11, 0));
    vecs.push_back(mk(0, CMD_WR_ADDR, 8'h00, 1, 0, 1, 8'h22, 0));
    vecs.push_back(mk(0, CMD_WR_ADDR, 8'h00, 1, 1, 0, 8'h22, 0));
    vecs.push_back(mk(1, CMD_RD_DATA, 8'h00, 1, 0, 0, 8'h22, 0));
    vecs.push_back(mk(0, CMD_WR_ADDR, 8'h00, 1, 0, 1, 8'h33, 0));
    vecs.push_back(mk(0, CMD_WR_ADDR, 8'h00, 1, 1, 0, 8'h33, 0));

    // Reset values.
    rst = 1'b1;
    applyStimulus(1'b0, CMD_WR_ADDR, 8'h00, 1'b1);
    tick();
    tick();
    checkOutput("reset tx_valid", if0.tx_valid, 0);
    checkOutput("reset dout", if0.dout, 0);
    checkOutput("reset err", if0.err, 0);
    checkOutput("reset dut1 err", if1.err, 0);
    rst = 1'b0;
    #1;
    checkOutput("post-reset rx_ready", if0.rx_ready, 1);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rv, vecs[i].cmd, vecs[i].pay, vecs[i].tr);
      tick();
      checkOutput($sformatf("vec%0d rx_ready", i), if0.rx_ready, vecs[i].expRdy);
      checkOutput($sformatf("vec%0d tx_valid", i), if0.tx_valid, vecs[i].expTv);
      checkOutput($sformatf("vec%0d dout", i), if0.dout, vecs[i].expDout);
      checkOutput($sformatf("vec%0d err", i), if0.err, vecs[i].expErr);
    end

    // Test 3: depth 200 range check, pointer hold on error, wrap at 199.
    sendCmd(CMD_WR_ADDR, 8'h10);
    sendCmd(CMD_WR_ADDR, 8'hC8);
    checkOutput("t3 err pulse", if1.err, 1);
    checkOutput("t3 dut0 no err", if0.err, 0);
    sendCmd(CMD_WR_DATA, 8'h5A);
    checkOutput("t3 err one cycle", if1.err, 0);
    sendCmd(CMD_WR_ADDR, 8'hC7);
    checkOutput("t3 C7 wr no err", if1.err, 0);
    sendCmd(CMD_WR_DATA, 8'h77);
    sendCmd(CMD_WR_DATA, 8'h99);
    sendCmd(CMD_RD_ADDR, 8'hC7);
    checkOutput("t3 C7 rd no err", if1.err, 0);
    readAndCheck("t3 rd C7", 1, 8'h77);
    readAndCheck("t3 rd wrap 0", 1, 8'h99);
    sendCmd(CMD_RD_ADDR, 8'h10);
    readAndCheck("t3 rd 10", 1, 8'h5A);

    // Test 4: backpressure holds the response and blocks commands.
    sendCmd(CMD_WR_ADDR, 8'h40);
    sendCmd(CMD_WR_DATA, 8'hC3);
    sendCmd(CMD_RD_ADDR, 8'h40);
    applyStimulus(1'b1, CMD_RD_DATA, 8'h00, 1'b0);
    tick();
    applyStimulus(1'b0, CMD_WR_ADDR, 8'h00, 1'b0);
    tick();
    checkOutput("t4 tx_valid", if0.tx_valid, 1);
    checkOutput("t4 dout", if0.dout, 8'hC3);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, CMD_WR_DATA, 8'hEE, 1'b0);
      tick();
      checkOutput($sformatf("t4 stall%0d dout", k), if0.dout, 8'hC3);
      checkOutput($sformatf("t4 stall%0d tx_valid", k), if0.tx_valid, 1);
      checkOutput($sformatf("t4 stall%0d rx_ready", k), if0.rx_ready, 0);
    end
    applyStimulus(1'b0, CMD_WR_ADDR, 8'h00, 1'b1);
    tick();
    checkOutput("t4 release tx_valid", if0.tx_valid, 0);
    checkOutput("t4 release rx_ready", if0.rx_ready, 1);
    sendCmd(CMD_WR_DATA, 8'h5C);
    sendCmd(CMD_RD_ADDR, 8'h40);
    readAndCheck("t4 rd 40", 0, 8'hC3);
    readAndCheck("t4 rd 41", 0, 8'h5C);

    // Test 5: reset during READ aborts the read; memory survives, pointers return to 0.
    sendCmd(CMD_RD_ADDR, 8'h05);
    applyStimulus(1'b1, CMD_RD_DATA, 8'h00, 1'b1);
    tick();
    rst = 1'b1;
    applyStimulus(1'b0, CMD_WR_ADDR, 8'h00, 1'b1);
    #1;
    checkOutput("t5 tx_valid in reset", if0.tx_valid, 0);
    checkOutput("t5 dout in reset", if0.dout, 0);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("t5 rx_ready after release", if0.rx_ready, 1);
    tick();
    checkOutput("t5 no tx_valid pulse", if0.tx_valid, 0);
    readAndCheck("t5 rd mem0", 0, 8'h33);

    // Test 6: no auto-increment; commands offered while busy are ignored.
    sendCmd(CMD_WR_ADDR, 8'h10);
    sendCmd(CMD_WR_DATA, 8'h4B);
    sendCmd(CMD_WR_DATA, 8'h4C);
    sendCmd(CMD_RD_ADDR, 8'h10);
    readAndCheck("t6 rd1", 2, 8'h4C);
    readAndCheck("t6 rd2", 2, 8'h4C);
    applyStimulus(1'b1, CMD_RD_DATA, 8'h00, 1'b0);
    tick();
    applyStimulus(1'b1, CMD_RD_ADDR, 8'h30, 1'b0);
    tick();
    applyStimulus(1'b1, CMD_WR_DATA, 8'h99, 1'b0);
    tick();
    checkOutput("t6 busy tx_valid", if2.tx_valid, 1);
    checkOutput("t6 busy dout", if2.dout, 8'h4C);
    checkOutput("t6 busy rx_ready", if2.rx_ready, 0);
    applyStimulus(1'b1, CMD_WR_ADDR, 8'h00, 1'b1);
    tick();
    checkOutput("t6 release tx_valid", if2.tx_valid, 0);
    readAndCheck("t6 rd3", 2, 8'h4C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
